// File: rtl/ncsp_mmd_divider.sv
// ncsp_mmd_divider: multi-modulus divider that turns each MASH ratio into one divided-clock period
// and requests the next ratio one cycle before every period boundary.
module ncsp_mmd_divider #(
  parameter int MIN_RATIO = 4,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [7:0]       i_ratio,
  input  logic             i_ratio_valid,
  output logic             o_ratio_req,
  output logic             o_div_clk,
  output logic             o_div_pulse,
  output logic [7:0]       o_ratio_cur,
  output logic             o_clamp,
  output logic             o_underrun,
  output logic [CNT_W-1:0] o_period_cnt
);
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  state_t           r_state;
  logic [7:0]       r_cnt, r_nc, r_ratio_cur;
  logic             r_req, r_div_clk, r_pulse, r_clamp, r_underrun;
  logic [CNT_W-1:0] r_period;
  logic             w_clamp;
  logic [7:0]       w_nc_in, w_nxt_nc, w_cnt_dec;
  assign w_clamp   = i_ratio < 8'(MIN_RATIO);
  assign w_nc_in   = w_clamp ? 8'(MIN_RATIO) : i_ratio;
  // at a RUN boundary without valid data the previous ratio is reused
  assign w_nxt_nc  = (r_state == RUN && !i_ratio_valid) ? r_nc : w_nc_in;
  assign w_cnt_dec = r_cnt - 8'd1;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_nc        <= '0;
      r_ratio_cur <= '0;
      r_period    <= '0;
      r_req       <= 1'b0;
      r_div_clk   <= 1'b0;
      r_pulse     <= 1'b0;
      r_clamp     <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_req      <= 1'b0;
      r_pulse    <= 1'b0;
      r_clamp    <= 1'b0;
      r_underrun <= 1'b0;
      if (r_state == IDLE) begin
        if (i_en) begin
          r_state <= PRIME;
          r_req   <= 1'b1;
        end
      end else if (!i_en && (r_state == PRIME || r_cnt == 8'd0)) begin
        r_state     <= IDLE;
        r_div_clk   <= 1'b0;
        r_ratio_cur <= '0;
        r_period    <= r_period + CNT_W'(r_state == RUN);
      end else if (r_state == RUN && r_cnt != 8'd0) begin
        r_cnt     <= w_cnt_dec;
        r_div_clk <= w_cnt_dec >= (r_nc >> 1);
        r_pulse   <= w_cnt_dec == 8'd0;
        r_req     <= i_en && w_cnt_dec == 8'd1;
      end else if (r_state == RUN || i_ratio_valid) begin
        r_state     <= RUN;
        r_nc        <= w_nxt_nc;
        r_cnt       <= w_nxt_nc - 8'd1;
        r_ratio_cur <= w_nxt_nc;
        r_div_clk   <= 1'b1;
        r_req       <= w_nxt_nc == 8'd2;
        r_clamp     <= i_ratio_valid && w_clamp;
        r_underrun  <= !i_ratio_valid;
        r_period    <= r_period + CNT_W'(r_state == RUN);
      end
    end
  end
  assign o_ratio_req  = r_req;
  assign o_div_clk    = r_div_clk;
  assign o_div_pulse  = r_pulse;
  assign o_ratio_cur  = r_ratio_cur;
  assign o_clamp      = r_clamp;
  assign o_underrun   = r_underrun;
  assign o_period_cnt = r_period;
endmodule

// File: tb/tb_ncsp_mmd_divider.sv
// tb_ncsp_mmd_divider: directed checks of period length, duty, request/pulse timing, clamp,
// underrun, graceful stop, async reset and period-count wrap.
module tb_ncsp_mmd_divider;
  logic       clk = 0, rst_n = 0, en = 0, valid = 0;
  logic [7:0] ratio = 0;
  logic       req, div_clk, pulse, clamp, underrun;
  logic [7:0] cur;
  logic [3:0] pcnt;
  int         n_pass = 0, n_chk = 0;
  int         seq[$], e_len[$], e_hi[$], e_cur[$], e_cl[$], e_un[$];
  always #5 clk = ~clk;
  ncsp_mmd_divider #(.MIN_RATIO(4), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_ratio(ratio), .i_ratio_valid(valid),
    .o_ratio_req(req), .o_div_clk(div_clk), .o_div_pulse(pulse), .o_ratio_cur(cur),
    .o_clamp(clamp), .o_underrun(underrun), .o_period_cnt(pcnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask
  task automatic do_reset;
    rst_n = 0; en = 0; valid = 0; ratio = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic apply(input int v);
    if (v < 0) valid = 0;
    else begin valid = 1; ratio = 8'(v); end
  endtask
  task automatic run_periods(input string tag);
    int n = e_len.size();
    int len = 0, hi = 0, rq = 0, rq_at = 0, cl = 0, un = 0, cur_v = 0, both = 0, p = 0, idx = 1, guard = 0;
    bit active = 0;
    apply(seq[0]); en = 1;
    while (p < n && guard < 4000) begin
      @(negedge clk); guard++;
      if (div_clk) active = 1;
      if (clamp && underrun) both++;
      if (active) begin
        len++; hi += int'(div_clk); cl += int'(clamp); un += int'(underrun);
        if (req) begin rq++; rq_at = len; end
        if (len == 1) cur_v = int'(cur);
        if (pulse) begin
          chk($sformatf("%s_len%0d", tag, p), len, e_len[p]);
          chk($sformatf("%s_hi%0d", tag, p), hi, e_hi[p]);
          chk($sformatf("%s_req%0d", tag, p), rq, 1);
          chk($sformatf("%s_reqpos%0d", tag, p), rq_at, len - 1);
          chk($sformatf("%s_cur%0d", tag, p), cur_v, e_cur[p]);
          chk($sformatf("%s_clamp%0d", tag, p), cl, e_cl[p]);
          chk($sformatf("%s_under%0d", tag, p), un, e_un[p]);
          p++; len = 0; hi = 0; rq = 0; rq_at = 0; cl = 0; un = 0;
          if (idx < seq.size()) begin apply(seq[idx]); idx++; end
        end
      end
    end
    chk({tag, "_done"}, p, n);
    chk({tag, "_pcnt"}, pcnt, (n - 1) % 16);
    chk({tag, "_both"}, both, 0);
  endtask
  initial begin
    int k, hi, rq;
    do_reset();
    chk("rst_outs", {req, div_clk, pulse, clamp, underrun}, 0);
    chk("rst_cur", cur, 0);
    chk("rst_pcnt", pcnt, 0);
    // start-up latency
    en = 1; ratio = 8; valid = 1;
    @(negedge clk);
    chk("start_req", req, 1);
    chk("start_clk", div_clk, 0);
    @(negedge clk);
    chk("first_clk", div_clk, 1);
    chk("first_req", req, 0);
    chk("first_cur", cur, 8);
    k = 0;
    do begin @(negedge clk); k++; end while (!pulse && k < 50);
    chk("first_pulse_lat", k, 7);
    do_reset();
    seq = '{8}; e_len = '{8, 8, 8}; e_hi = '{4, 4, 4}; e_cur = '{8, 8, 8}; e_cl = '{0, 0, 0}; e_un = '{0, 0, 0};
    run_periods("r8");
    do_reset();
    seq = '{9}; e_len = '{9, 9}; e_hi = '{5, 5}; e_cur = '{9, 9}; e_cl = '{0, 0}; e_un = '{0, 0};
    run_periods("r9");
    do_reset();
    seq = '{2, 2, 0}; e_len = '{4, 4, 4}; e_hi = '{2, 2, 2}; e_cur = '{4, 4, 4}; e_cl = '{1, 1, 1}; e_un = '{0, 0, 0};
    run_periods("clamp");
    do_reset();
    seq = '{8, 9, 8, 8, 9}; e_len = '{8, 9, 8, 8, 9}; e_hi = '{4, 5, 4, 4, 5};
    e_cur = '{8, 9, 8, 8, 9}; e_cl = '{0, 0, 0, 0, 0}; e_un = '{0, 0, 0, 0, 0};
    run_periods("frac");
    do_reset();
    seq = '{10, -1, 7}; e_len = '{10, 10, 7}; e_hi = '{5, 5, 4}; e_cur = '{10, 10, 7}; e_cl = '{0, 0, 0}; e_un = '{0, 1, 0};
    run_periods("under");
    do_reset();
    seq = '{4}; e_len.delete(); e_hi.delete(); e_cur.delete(); e_cl.delete(); e_un.delete();
    for (int i = 0; i < 18; i++) begin
      e_len.push_back(4); e_hi.push_back(2); e_cur.push_back(4); e_cl.push_back(0); e_un.push_back(0);
    end
    run_periods("wrap");
    // graceful stop at ratio 12
    do_reset();
    en = 1; ratio = 12; valid = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!div_clk && k < 10);
    k = 1; rq = 0;
    repeat (4) begin @(negedge clk); k++; rq += int'(req); end
    en = 0;
    do begin @(negedge clk); k++; rq += int'(req); end while (!pulse && k < 50);
    chk("stop_len", k, 12);
    chk("stop_req", rq, 0);
    @(negedge clk);
    chk("stop_outs", {req, div_clk, pulse, clamp, underrun}, 0);
    chk("stop_cur", cur, 0);
    chk("stop_pcnt", pcnt, 1);
    hi = 0;
    repeat (15) begin @(negedge clk); hi += int'(div_clk | req | pulse); end
    chk("stop_idle", hi, 0);
    // async reset mid-period at ratio 20
    do_reset();
    en = 1; ratio = 20; valid = 1;
    k = 0;
    while (pcnt != 1 && k < 100) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    chk("pre_rst_clk", div_clk, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_outs", {req, div_clk, pulse, clamp, underrun}, 0);
    chk("arst_cur", cur, 0);
    chk("arst_pcnt", pcnt, 0);
    do_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ncsp_mmd_divider.md
# ncsp_mmd_divider

Programmable multi-modulus divider controller that consumes the per-cycle division ratio produced by the MASH top-level output (`o_mash_out`, integer plus fractional offset). It turns each ratio into one divided-clock period. At each period boundary it issues a one-cycle request that advances the MASH by one sample, so the modulator runs at the divided rate. It sits directly downstream of the MASH top and drives the divided clock, boundary pulse and monitoring outputs.

## Interface
- `MIN_RATIO`, default 4: smallest legal ratio; lower inputs are clamped. Must be ≥ 2.
- `CNT_W`, default 16: width of the period counter.
- `i_clk` in 1: divider input clock (VCO-rate model).
- `i_rst_n` in 1: reset. **Asynchronous, active-low; one clock only.**
- `i_en` in 1: run enable, sampled on `i_clk`.
- `i_ratio` in 8: division ratio N from the MASH output.
- `i_ratio_valid` in 1: `i_ratio` is valid this cycle.
- `o_ratio_req` out 1: one-cycle request for the next ratio (MASH clock enable).
- `o_div_clk` out 1: divided clock, ceil(N/2) cycles high then floor(N/2) cycles low.
- `o_div_pulse` out 1: high on the last cycle of each period.
- `o_ratio_cur` out 8: ratio of the current period, after clamping.
- `o_clamp` out 1: one-cycle pulse when the loaded ratio was clamped.
- `o_underrun` out 1: one-cycle pulse when no valid ratio was present at a boundary.
- `o_period_cnt` out CNT_W: number of completed periods; wraps.

## Operation
- **States:** IDLE, PRIME, RUN. Down-counter `cnt[7:0]`. All outputs are registered.
- **IDLE:** all outputs 0. If `i_en`=1, go to PRIME.
  - `o_ratio_req`=1 during the first PRIME cycle only.
- **PRIME:** wait for `i_ratio_valid`.
  - When valid: load `Nc = max(i_ratio, MIN_RATIO)`, set `cnt = Nc-1`, go to RUN.
  - Pulse `o_clamp` if clamped.
  - If `i_en` drops while in PRIME, return to IDLE.
- **RUN:** `cnt` decrements every cycle.
  - `o_div_clk = (cnt >= Nc>>1)`.
  - When `cnt`==1 and `i_en`=1: `o_ratio_req`=1.
  - When `cnt`==0: `o_div_pulse`=1.
- **Boundary (`cnt`==0):** `o_period_cnt` increments, then:
  - `i_en`=0: go to IDLE. The period in progress always completes first (graceful stop).
  - `i_en`=1 and `i_ratio_valid`=1: load the new clamped ratio, `cnt = Nc-1`.
  - `i_en`=1 and `i_ratio_valid`=0: reuse the previous `Nc` and pulse `o_underrun`.
- **Ratio width:** 8-bit unsigned, range MIN_RATIO..255. There is no upper clamp. A ratio of 0 or 1 is always clamped.
- **`o_period_cnt`:** wraps from 2^CNT_W−1 to 0 and is never cleared except by reset.
- **Simultaneous events:**
  - `i_ratio_valid` outside the boundary cycle (or the PRIME wait) is ignored.
  - Clamp and load in the same cycle: both take effect.
  - `o_clamp` and `o_underrun` are never both high.

## Timing
- **Reset:** `i_rst_n`=0 immediately forces state IDLE and sets `cnt`, `Nc`, `o_ratio_cur`, `o_period_cnt` and all 1-bit outputs to 0. Reset may assert mid-period; no period completes and no pulse is emitted.
- **Start-up latency:**
  - `i_en` sampled high at edge t → `o_ratio_req` high during cycle t..t+1.
  - With valid data at edge t+1, the first period starts at t+1. `o_div_clk` rises then.
  - First `o_div_pulse` occurs Nc−1 cycles later.
- **Request timing:** `o_ratio_req` leads the boundary by exactly one cycle. The upstream must present `i_ratio_valid` in the boundary cycle.
- **Steady state:**
  - Period = exactly Nc cycles.
  - `o_ratio_req` and `o_div_pulse` each occur once per period, one cycle apart.
  - `o_ratio_cur` updates on the first cycle of the period it describes.

## Test plan
- **Constant ratio:** `i_ratio`=8, always valid → period 8, `o_div_clk` 4 high/4 low, `o_ratio_req` at `cnt`==1, `o_period_cnt` +1 per 8 cycles.
- **Odd ratio:** `i_ratio`=9 → `o_div_clk` 5 high/4 low, `o_ratio_cur`=9.
- **Clamp:** `i_ratio`=2, MIN_RATIO=4 → period 4, one `o_clamp` pulse per load, `o_ratio_cur`=4. `i_ratio`=0 gives the same result.
- **Fractional sequence:** ratio sequence 8,9,8,8,9 → period lengths exactly 8,9,8,8,9; one `o_ratio_req` per period; mean ratio 8.4 over 5 periods.
- **Underrun:** hold `i_ratio_valid`=0 at one boundary after ratio 10 → next period is 10 cycles, one `o_underrun` pulse, then normal resumption with the next valid ratio.
- **Stop and reset:**
  - Drop `i_en` mid-period at ratio 12 → the period finishes at 12 cycles, no `o_ratio_req`, state IDLE.
  - Assert `i_rst_n`=0 mid-period at ratio 20 → all outputs 0 without waiting for a clock edge; `o_period_cnt`=0.
